// File: rtl/memory_access_stage.sv
// MEM pipeline stage: one req/ack data-memory transaction per load/store, with lane alignment and load extension.
// Optional build macro MEM_MISALIGN_TRAP_EN traps misaligned accesses instead of issuing them.
module memory_access_stage #(
    parameter int ADDR_WIDTH     = 64,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_enable,
    input  logic [6:0]            mem_opcode,
    input  logic [2:0]            mem_funct3,
    input  logic [63:0]           alu_result,
    input  logic [63:0]           store_data,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [63:0]           dmem_wdata,
    output logic [7:0]            dmem_wstrb,
    input  logic                  dmem_ack,
    input  logic [63:0]           dmem_rdata,
    output logic [63:0]           loaded_data,
    output logic                  mem_done,
    output logic                  mem_timeout
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic                  misalign_fault
`endif
);

    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [7:0] TIMEOUT_MAX = 8'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [7:0] lane_strobe(input logic [2:0] f3, input logic [2:0] off);
        logic [7:0] mask;
        case (f3[1:0])
            2'b00:   mask = 8'h01;
            2'b01:   mask = 8'h03;
            2'b10:   mask = 8'h0F;
            default: mask = 8'hFF;
        endcase
        // Shifting in 8 bits drops strobes that would spill into the next word.
        return mask << off;
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [2:0] off);
        logic [2:0] low_bits;
        case (f3[1:0])
            2'b00:   low_bits = 3'b000;
            2'b01:   low_bits = 3'b001;
            2'b10:   low_bits = 3'b011;
            default: low_bits = 3'b111;
        endcase
        return (off & low_bits) != 3'b000;
    endfunction

    function automatic logic [63:0] extend_load(input logic [2:0] f3, input logic [63:0] word,
                                                input logic [2:0] off);
        logic [63:0] lane;
        lane = word >> {off, 3'b000};
        case (f3)
            3'b000:  extend_load = {{56{lane[7]}}, lane[7:0]};
            3'b001:  extend_load = {{48{lane[15]}}, lane[15:0]};
            3'b010:  extend_load = {{32{lane[31]}}, lane[31:0]};
            3'b100:  extend_load = {56'd0, lane[7:0]};
            3'b101:  extend_load = {48'd0, lane[15:0]};
            3'b110:  extend_load = {32'd0, lane[31:0]};
            default: extend_load = lane;
        endcase
    endfunction

    state_t      state_r;
    logic [7:0]  timeout_cnt_r;
    logic [2:0]  funct3_r;
    logic [2:0]  offset_r;
    logic        abandon_r;

    logic        is_load_s;
    logic        is_store_s;
    logic        trap_s;
    logic [2:0]  offset_s;
    logic [7:0]  wstrb_s;
    logic [63:0] wdata_s;

    // Decode the incoming op and pre-align store lanes.
    always_comb begin
        is_load_s  = (mem_opcode == OP_LOAD);
        is_store_s = (mem_opcode == OP_STORE);
        offset_s   = alu_result[2:0];
        wstrb_s    = lane_strobe(mem_funct3, offset_s);
        wdata_s    = store_data << {offset_s, 3'b000};
`ifdef MEM_MISALIGN_TRAP_EN
        trap_s     = (is_load_s | is_store_s) & misaligned(mem_funct3, offset_s);
`else
        trap_s     = 1'b0;
`endif
    end

    // Stage FSM with all outputs registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r        <= IDLE;
            timeout_cnt_r  <= 8'd0;
            funct3_r       <= 3'd0;
            offset_r       <= 3'd0;
            abandon_r      <= 1'b0;
            dmem_req       <= 1'b0;
            dmem_we        <= 1'b0;
            dmem_addr      <= '0;
            dmem_wdata     <= 64'd0;
            dmem_wstrb     <= 8'd0;
            loaded_data    <= 64'd0;
            mem_done       <= 1'b0;
            mem_timeout    <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_fault <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (mem_enable) begin
`ifdef MEM_MISALIGN_TRAP_EN
                        misalign_fault <= trap_s;
`endif
                        if ((is_load_s || is_store_s) && !trap_s) begin
                            state_r       <= REQ;
                            dmem_req      <= 1'b1;
                            dmem_we       <= is_store_s;
                            dmem_addr     <= {alu_result[ADDR_WIDTH-1:3], 3'b000};
                            dmem_wdata    <= is_store_s ? wdata_s : 64'd0;
                            dmem_wstrb    <= is_store_s ? wstrb_s : 8'd0;
                            funct3_r      <= mem_funct3;
                            offset_r      <= offset_s;
                            timeout_cnt_r <= 8'd0;
                            abandon_r     <= 1'b0;
                            mem_timeout   <= 1'b0;
                        end else begin
                            state_r  <= DONE;
                            mem_done <= 1'b1;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                REQ: begin
                    if (dmem_ack || (timeout_cnt_r == TIMEOUT_MAX)) begin
                        state_r    <= DONE;
                        dmem_req   <= 1'b0;
                        dmem_we    <= 1'b0;
                        dmem_wstrb <= 8'd0;
                        // An op abandoned by write-back still finishes, but raises no done.
                        mem_done   <= mem_enable & ~abandon_r;
                        if (dmem_ack) begin
                            if (!dmem_we) begin
                                loaded_data <= extend_load(funct3_r, dmem_rdata, offset_r);
                            end else begin
                                loaded_data <= loaded_data;
                            end
                        end else begin
                            mem_timeout <= 1'b1;
                        end
                    end else begin
                        timeout_cnt_r <= timeout_cnt_r + 8'd1;
                        abandon_r     <= abandon_r | ~mem_enable;
                    end
                end
                DONE: begin
                    if (!mem_enable || !mem_done) begin
                        state_r  <= IDLE;
                        mem_done <= 1'b0;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    dmem_req <= 1'b0;
                    mem_done <= 1'b0;
                end
            endcase
        end
    end

endmodule
